fifo36_to_ll8: RTL and testbench

//  Read side of the 36-bit packet FIFO path: drains fifo36 words (src_rdy/dst_rdy) and

---
 rtl/fifo36_to_ll8.sv | 157 +++++++++++++++
 tb/tb_fifo36_to_ll8.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo36_to_ll8.sv
// Drains 36-bit packet FIFO words and serialises them into an 8-bit link-layer
// byte stream with SOF/EOF, dropping and counting words that break framing.
module fifo36_to_ll8 #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clear,
    input  logic [35:0]      f36_datain,
    input  logic             f36_src_rdy_i,
    output logic             f36_dst_rdy_o,
    output logic [7:0]       ll_data,
    output logic             ll_sof,
    output logic             ll_eof,
    output logic             ll_src_rdy,
    input  logic             ll_dst_rdy,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_hold_data;
    logic             r_hold_sof;
    logic             r_hold_eof;
    logic [1:0]       r_hold_occ;
    logic             r_hold_valid;
    logic [1:0]       r_byte_idx;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic [1:0]       w_last_idx;
    logic             w_last_byte;
    logic             w_ll_xfer;
    logic             w_f36_xfer;
    logic             w_in_sof;
    logic             w_in_eof;
    logic             w_load;
    logic             w_err;
    logic [1:0]       w_lane;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}})
            return v;
        return v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] lane);
        case (lane)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    // occ only shortens the final word of a packet; occ==0 means all four bytes
    assign w_last_idx  = (r_hold_eof && (r_hold_occ != 2'd0)) ? (r_hold_occ - 2'd1) : 2'd3;
    assign w_last_byte = (r_byte_idx == w_last_idx);
    assign w_ll_xfer   = r_hold_valid & ll_dst_rdy;

    // A new word may be taken on the same cycle the last byte leaves, keeping full rate
    assign f36_dst_rdy_o = ~clear & (~r_hold_valid | (w_ll_xfer & w_last_byte));
    assign w_f36_xfer    = f36_src_rdy_i & f36_dst_rdy_o;
    assign w_in_sof      = f36_datain[32];
    assign w_in_eof      = f36_datain[33];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        if (w_f36_xfer) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_sof) begin
                        w_load      = 1'b1;
                        w_state_nxt = w_in_eof ? ST_IDLE : ST_IN_PKT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    // SOF here truncates the open packet but still starts the new one
                    w_load      = 1'b1;
                    w_err       = w_in_sof;
                    w_state_nxt = w_in_eof ? ST_IDLE : ST_IN_PKT;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            r_state <= ST_IDLE;
        else if (clear)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_hold_valid <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
        end else if (clear) begin
            r_hold_valid <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err)
                r_err_count <= sat_inc(r_err_count);
            if (w_load) begin
                r_hold_valid <= 1'b1;
                r_byte_idx   <= 2'd0;
            end else if (w_ll_xfer) begin
                if (w_last_byte) begin
                    r_hold_valid <= 1'b0;
                    r_byte_idx   <= 2'd0;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

    // Payload needs no reset: every use of it is qualified by r_hold_valid
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_hold_data <= f36_datain[31:0];
            r_hold_sof  <= w_in_sof;
            r_hold_eof  <= w_in_eof;
            r_hold_occ  <= f36_datain[35:34];
        end
    end

    assign w_lane     = BIG_ENDIAN ? ~r_byte_idx : r_byte_idx;
    assign ll_src_rdy = r_hold_valid;
    assign ll_data    = r_hold_valid ? pick_byte(r_hold_data, w_lane) : 8'h00;
    assign ll_sof     = r_hold_valid & r_hold_sof & (r_byte_idx == 2'd0);
    assign ll_eof     = r_hold_valid & r_hold_eof & w_last_byte;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign busy       = (r_state == ST_IN_PKT);

endmodule

// File: tb/tb_fifo36_to_ll8.sv
// Directed bench for fifo36_to_ll8: one big-endian 16-bit-counter instance and one
// little-endian 2-bit-counter instance share the same stimulus.
module tb_fifo36_to_ll8;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        clear;
    logic [35:0] f36_datain;
    logic        f36_src_rdy_i;
    logic        ll_dst_rdy;

    logic        f36_dst_rdy_o, ll_sof, ll_eof, ll_src_rdy, err_pulse, busy;
    logic [7:0]  ll_data;
    logic [15:0] err_count;

    logic        d2_f36_dst_rdy_o, d2_ll_sof, d2_ll_eof, d2_ll_src_rdy, d2_err_pulse, d2_busy;
    logic [7:0]  d2_ll_data;
    logic [1:0]  d2_err_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo36_to_ll8 #(.BIG_ENDIAN(1'b1), .ERR_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .clear(clear),
        .f36_datain(f36_datain), .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(f36_dst_rdy_o),
        .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof), .ll_src_rdy(ll_src_rdy),
        .ll_dst_rdy(ll_dst_rdy), .err_pulse(err_pulse), .err_count(err_count), .busy(busy)
    );

    fifo36_to_ll8 #(.BIG_ENDIAN(1'b0), .ERR_W(2)) dut2 (
        .clk(clk), .arst_n(arst_n), .clear(clear),
        .f36_datain(f36_datain), .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(d2_f36_dst_rdy_o),
        .ll_data(d2_ll_data), .ll_sof(d2_ll_sof), .ll_eof(d2_ll_eof), .ll_src_rdy(d2_ll_src_rdy),
        .ll_dst_rdy(ll_dst_rdy), .err_pulse(d2_err_pulse), .err_count(d2_err_count), .busy(d2_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_byte(input string tag, input logic [7:0] d, input logic s,
                            input logic e, input logic dr);
        chk({tag, "_vld"}, {31'd0, ll_src_rdy}, 32'd1);
        chk({tag, "_data"}, {24'd0, ll_data}, {24'd0, d});
        chk({tag, "_sof"}, {31'd0, ll_sof}, {31'd0, s});
        chk({tag, "_eof"}, {31'd0, ll_eof}, {31'd0, e});
        chk({tag, "_dstrdy"}, {31'd0, f36_dst_rdy_o}, {31'd0, dr});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [35:0] word(input logic [1:0] occ, input logic eof,
                                         input logic sof, input logic [31:0] d);
        return {occ, eof, sof, d};
    endfunction

    initial begin
        arst_n        = 1'b0;
        clear         = 1'b0;
        f36_datain    = '0;
        f36_src_rdy_i = 1'b0;
        ll_dst_rdy    = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_vld", {31'd0, ll_src_rdy}, 32'd0);
        chk("rst_sof", {31'd0, ll_sof}, 32'd0);
        chk("rst_eof", {31'd0, ll_eof}, 32'd0);
        chk("rst_data", {24'd0, ll_data}, 32'd0);
        chk("rst_errp", {31'd0, err_pulse}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dstrdy", {31'd0, f36_dst_rdy_o}, 32'd1);
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
        step();
        arst_n = 1'b1;

        // single-word packet
        f36_datain = word(2'd0, 1'b1, 1'b1, 32'hA1B2C3D4); f36_src_rdy_i = 1'b1;
        #1; chk("t1_accept", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t1_b0", 8'hA1, 1'b1, 1'b0, 1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_le_b0", {24'd0, d2_ll_data}, 32'hD4);
        chk("t1_le_sof", {31'd0, d2_ll_sof}, 32'd1);
        step();
        #1; exp_byte("t1_b1", 8'hB2, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t1_b2", 8'hC3, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t1_b3", 8'hD4, 1'b0, 1'b1, 1'b1);
        chk("t1_le_b3", {24'd0, d2_ll_data}, 32'hA1);
        step();
        #1; chk("t1_done", {31'd0, ll_src_rdy}, 32'd0);

        // three-word packet, final word two bytes, continuous ready
        f36_datain = word(2'd0, 1'b0, 1'b1, 32'h11223344); f36_src_rdy_i = 1'b1;
        #1; chk("t2_accept0", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        f36_datain = word(2'd0, 1'b0, 1'b0, 32'h55667788);
        #1; exp_byte("t2_b0", 8'h11, 1'b1, 1'b0, 1'b0);
        chk("t2_busy_a", {31'd0, busy}, 32'd1); step();
        #1; exp_byte("t2_b1", 8'h22, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t2_b2", 8'h33, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t2_b3", 8'h44, 1'b0, 1'b0, 1'b1); step();
        f36_datain = word(2'd2, 1'b1, 1'b0, 32'h99AABBCC);
        #1; exp_byte("t2_b4", 8'h55, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t2_b5", 8'h66, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t2_b6", 8'h77, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t2_b7", 8'h88, 1'b0, 1'b0, 1'b1);
        chk("t2_busy_b", {31'd0, busy}, 32'd1); step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t2_b8", 8'h99, 1'b0, 1'b0, 1'b0);
        chk("t2_busy_c", {31'd0, busy}, 32'd0);
        chk("t2_le_b8", {24'd0, d2_ll_data}, 32'hCC); step();
        #1; exp_byte("t2_b9", 8'hAA, 1'b0, 1'b1, 1'b1); step();
        #1; chk("t2_done", {31'd0, ll_src_rdy}, 32'd0);

        // downstream stall 1,0,0,1 mid-word
        f36_datain = word(2'd0, 1'b1, 1'b1, 32'hDEADBEEF); f36_src_rdy_i = 1'b1;
        #1; step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t3_b0", 8'hDE, 1'b1, 1'b0, 1'b0); step();
        ll_dst_rdy = 1'b0;
        #1; exp_byte("t3_st0", 8'hAD, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t3_st1", 8'hAD, 1'b0, 1'b0, 1'b0); step();
        ll_dst_rdy = 1'b1;
        #1; exp_byte("t3_b1", 8'hAD, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t3_b2", 8'hBE, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t3_b3", 8'hEF, 1'b0, 1'b1, 1'b1); step();
        #1; chk("t3_done", {31'd0, ll_src_rdy}, 32'd0);

        // non-SOF words while idle are consumed as errors; narrow counter saturates
        f36_datain = word(2'd0, 1'b0, 1'b0, 32'h12345678); f36_src_rdy_i = 1'b1;
        #1; chk("t4_accept", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        f36_src_rdy_i = 1'b0;
        #1; chk("t4_errp", {31'd0, err_pulse}, 32'd1);
        chk("t4_cnt1", {16'd0, err_count}, 32'd1);
        chk("t4_d2cnt1", {30'd0, d2_err_count}, 32'd1);
        chk("t4_novld", {31'd0, ll_src_rdy}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0); step();
        f36_src_rdy_i = 1'b1;
        #1; chk("t4_errp_once", {31'd0, err_pulse}, 32'd0); step();
        step(); step(); step();
        f36_src_rdy_i = 1'b0;
        #1; chk("t4_errp5", {31'd0, err_pulse}, 32'd1);
        chk("t4_cnt5", {16'd0, err_count}, 32'd5);
        chk("t4_d2sat", {30'd0, d2_err_count}, 32'd3);
        chk("t4_novld5", {31'd0, ll_src_rdy}, 32'd0); step();

        // SOF word while a packet is open
        f36_datain = word(2'd0, 1'b0, 1'b1, 32'h01020304); f36_src_rdy_i = 1'b1;
        #1; step();
        f36_datain = word(2'd0, 1'b0, 1'b1, 32'hA0B0C0D0);
        #1; exp_byte("t5_b0", 8'h01, 1'b1, 1'b0, 1'b0); step();
        #1; exp_byte("t5_b1", 8'h02, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t5_b2", 8'h03, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t5_b3", 8'h04, 1'b0, 1'b0, 1'b1); step();
        f36_datain = word(2'd1, 1'b1, 1'b0, 32'hE0000000);
        #1; exp_byte("t5_n0", 8'hA0, 1'b1, 1'b0, 1'b0);
        chk("t5_errp", {31'd0, err_pulse}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_cnt", {16'd0, err_count}, 32'd6);
        chk("t5_d2cnt", {30'd0, d2_err_count}, 32'd3); step();
        #1; exp_byte("t5_n1", 8'hB0, 1'b0, 1'b0, 1'b0);
        chk("t5_errp_off", {31'd0, err_pulse}, 32'd0); step();
        #1; exp_byte("t5_n2", 8'hC0, 1'b0, 1'b0, 1'b0); step();
        #1; exp_byte("t5_n3", 8'hD0, 1'b0, 1'b0, 1'b1); step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t5_e0", 8'hE0, 1'b0, 1'b1, 1'b1);
        chk("t5_idle", {31'd0, busy}, 32'd0); step();
        #1; chk("t5_done", {31'd0, ll_src_rdy}, 32'd0);

        // clear during second byte of a word
        f36_datain = word(2'd0, 1'b0, 1'b1, 32'h31323334); f36_src_rdy_i = 1'b1;
        #1; step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t6_b0", 8'h31, 1'b1, 1'b0, 1'b0); step();
        clear = 1'b1; f36_src_rdy_i = 1'b1; f36_datain = word(2'd0, 1'b1, 1'b1, 32'h77777777);
        #1; chk("t6_clr_dstrdy", {31'd0, f36_dst_rdy_o}, 32'd0);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1); step();
        clear = 1'b0; f36_datain = word(2'd2, 1'b1, 1'b1, 32'h41420000);
        #1; chk("t6_novld", {31'd0, ll_src_rdy}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cnt_kept", {16'd0, err_count}, 32'd6);
        chk("t6_dstrdy", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t6_p0", 8'h41, 1'b1, 1'b0, 1'b0);
        chk("t6_noerr", {31'd0, err_pulse}, 32'd0); step();
        #1; exp_byte("t6_p1", 8'h42, 1'b0, 1'b1, 1'b1); step();
        #1; chk("t6_done", {31'd0, ll_src_rdy}, 32'd0);

        // asynchronous reset during second byte of a word
        f36_datain = word(2'd0, 1'b0, 1'b1, 32'h51525354); f36_src_rdy_i = 1'b1;
        #1; step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t7_b0", 8'h51, 1'b1, 1'b0, 1'b0); step();
        #1; exp_byte("t7_b1", 8'h52, 1'b0, 1'b0, 1'b0);
        chk("t7_busy_pre", {31'd0, busy}, 32'd1);
        arst_n = 1'b0;
        #1; chk("t7_rst_vld", {31'd0, ll_src_rdy}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy}, 32'd0);
        chk("t7_rst_cnt", {16'd0, err_count}, 32'd0);
        chk("t7_rst_dstrdy", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        arst_n = 1'b1; f36_datain = word(2'd1, 1'b1, 1'b1, 32'h61000000); f36_src_rdy_i = 1'b1;
        #1; chk("t7_accept", {31'd0, f36_dst_rdy_o}, 32'd1); step();
        f36_src_rdy_i = 1'b0;
        #1; exp_byte("t7_p0", 8'h61, 1'b1, 1'b1, 1'b1);
        chk("t7_noerr", {31'd0, err_pulse}, 32'd0); step();
        #1; chk("t7_done", {31'd0, ll_src_rdy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
